// File: rtl/piso_pkg.sv
// piso_pkg: shared types, defaults and helpers for the serial transmit datapath
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int WIDTH_DEF = 4;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/bit_cnt.sv
// bit_cnt: loadable down-counter with a zero flag that never wraps below zero
module bit_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load has priority; decrement is blocked at zero
  always_comb begin
    zero_o = cnt_q == '0;
    cnt_d  = load_i ? val_i : (dec_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
  end
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load and valid/last stream
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             zero, step, accept;
  // handshake, next state and serial outputs; shifting past the last bit leaves shreg at zero
  always_comb begin
    step       = state_q == SHIFT && shift_en;
    load_ready = !rst && (state_q == IDLE || (step && zero));
    accept     = load_valid && load_ready;
    state_d    = accept ? SHIFT : (step && zero) ? IDLE : state_q;
    shreg_d    = accept ? D : step ? (MSB_FIRST ? shreg_q << 1 : shreg_q >> 1) : shreg_q;
    sout_valid = state_q == SHIFT;
    sout       = sout_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    sout_last  = sout_valid && zero;
    busy       = sout_valid;
  end
  // state and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end
  bit_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .dec_i  (step),
    .val_i  (CW'(WIDTH - 1)),
    .zero_o (zero)
  );
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter for the 4-bit register datapath. It accepts a parallel word over a valid/ready load handshake, then shifts it out one bit per enabled clock with valid and last markers. It sits downstream of the parallel register stage and converts its captured bus into a serial stream for a single-wire consumer.

## Interface
- WIDTH, 4, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- D  input  WIDTH  parallel word to transmit
- load_valid  input  1  D is valid for loading
- load_ready  output  1  block can accept D this cycle
- shift_en  input  1  advance one bit this cycle; hold when low
- sout  output  1  current serial bit
- sout_valid  output  1  sout carries a payload bit
- sout_last  output  1  sout is the final bit of the word
- busy  output  1  word in flight (state SHIFT)

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: load_ready=1, sout_valid=0, sout=0. On load_valid && load_ready at a rising edge, capture D into shift register, set bit counter to WIDTH-1, go to SHIFT.
- SHIFT: sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0). sout_valid=1. sout_last=1 when counter==0.
- shift_en=1 in SHIFT with counter>0: shift one position toward the output end, fill 0, decrement counter.
- shift_en=0: shreg, counter, state, sout all hold.
- shift_en=1 with counter==0: last bit consumed. If load_valid=1 in the same cycle, load the new word, reload the counter, and stay in SHIFT with no bubble. Otherwise go to IDLE.
- load_ready = (state==IDLE) || (state==SHIFT && counter==0 && shift_en). It is combinational from state, counter and shift_en, and is 0 while rst=1.
- load_valid in SHIFT when load_ready=0 is ignored. D is not captured, and the source must hold it.
- Changes on D outside the accepting edge have no effect.
- Counter width: $clog2(WIDTH). No wrap: the counter never decrements below 0.

## Timing
- Reset, at the first rising edge with rst=1: state=IDLE, shreg=0, counter=0, sout=0, sout_valid=0, sout_last=0, busy=0. load_ready=0 while rst is held, and 1 in the first cycle after release.
- Reset mid-word aborts the word. No partial bits are emitted after the reset edge.
- Load latency: word accepted at edge N, so its first bit is valid on sout after edge N.
- With shift_en held high, bits occupy cycles N+1 … N+WIDTH, and sout_last is asserted in cycle N+WIDTH.
- Back-to-back throughput: 1 bit/cycle sustained, with no idle cycle between words.
- Simultaneous rst and load_valid: reset wins and no load occurs.

## Structure
- Shared package piso_pkg holds:
  - typedef state_t {IDLE, SHIFT}
  - localparam default WIDTH=4
  - function for counter width
- One sub-module is natural: bit_cnt. It is a loadable down-counter with load, dec and zero-flag signals, also reusable by a future serial-in receiver.
- Shift register and FSM live in piso_tx.

## Test plan
- Reset: apply rst for 2 cycles with load_valid=1 and D=4'b1111. Required: all outputs 0, load_ready=0, nothing loaded. After release, load_ready=1.
- Single word, MSB_FIRST=1, shift_en=1: load D=4'b1110. Required: sout=1,1,1,0 over 4 cycles, sout_last only on the 4th, then IDLE with sout_valid=0.
- LSB-first: MSB_FIRST=0, load D=4'b1110. Required: sout=0,1,1,1.
- Stall: load 4'b1010 and drop shift_en for 3 cycles after the 2nd bit. Required: sout holds 0 and sout_valid stays 1 during the stall, then the stream resumes 1,0. Total cycles = 4 + 3.
- Back-to-back: hold load_valid=1 with D=4'b1111 then 4'b0000, loaded at sout_last. Required: 8 consecutive valid bits 1,1,1,1,0,0,0,0 with no gap, and load_ready pulsed only on each last-bit cycle.
- Reset mid-word: assert rst after the 2nd bit of 4'b1101. Required: sout_valid=0 from the next cycle, and a new load of 4'b0110 then transmits 0,1,1,0 cleanly.
